// File: rtl/dht11_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dht11_responder                                            |
// | Description : DHT11 sensor emulator; answers a host start pulse with ACK |
// |               and a 40-bit frame. Option macro: DHT11_FAULT_INJECT_EN    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dht11_responder #(
  parameter int TICKS_PER_US = 50,
  parameter int START_MIN_US = 18000,
  parameter int RESP_DLY_US  = 30,
  parameter int ACK_US       = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_HI_US   = 27,
  parameter int BIT1_HI_US   = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic       dir,
  output logic       data_out,
`ifdef DHT11_FAULT_INJECT_EN
  input  logic       fault_inj,
`endif
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  output logic       busy,
  output logic       frame_done
);

  localparam int              TW          = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [TW-1:0]   C_TICK_LAST = TW'(TICKS_PER_US - 1);
  localparam logic [19:0]     C_START     = 20'(START_MIN_US);
  localparam logic [19:0]     C_RESP      = 20'(RESP_DLY_US);
  localparam logic [19:0]     C_ACK       = 20'(ACK_US);
  localparam logic [19:0]     C_BLO       = 20'(BIT_LOW_US);
  localparam logic [19:0]     C_B0        = 20'(BIT0_HI_US);
  localparam logic [19:0]     C_B1        = 20'(BIT1_HI_US);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HOST_LOW = 4'd1,
    S_WAIT_DLY = 4'd2,
    S_ACK_LO   = 4'd3,
    S_ACK_HI   = 4'd4,
    S_BIT_LO   = 4'd5,
    S_BIT_HI   = 4'd6,
    S_END_LO   = 4'd7
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [TW-1:0] r_tick;
  logic [19:0]   r_us;
  logic [39:0]   r_frame;
  logic [5:0]    r_bit;
  logic          r_dir;
  logic          r_busy;
  logic          r_done;

  logic          w_line;
  logic [19:0]   w_dur;
  logic          w_tick_last;
  logic          w_last;
  logic [7:0]    w_sum;
  logic [7:0]    w_csum;

  assign w_line      = r_sync2;
  assign w_tick_last = (r_tick == C_TICK_LAST);
  assign w_last      = w_tick_last && (w_dur != 20'd0) && (r_us == w_dur - 20'd1);
  assign w_sum       = hum_int + hum_dec + tmp_int + tmp_dec;
`ifdef DHT11_FAULT_INJECT_EN
  assign w_csum      = w_sum ^ {7'd0, fault_inj};
`else
  assign w_csum      = w_sum;
`endif

  assign dir        = r_dir;
  assign data_out   = 1'b0;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Idle-high reset value keeps a reset from looking like a host start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end

  // Zero duration marks the untimed states so the generic expiry never fires there.
  always_comb begin
    w_dur = 20'd0;
    case (r_state)
      S_WAIT_DLY:         w_dur = C_RESP;
      S_ACK_LO, S_ACK_HI: w_dur = C_ACK;
      S_BIT_LO, S_END_LO: w_dur = C_BLO;
      S_BIT_HI:           w_dur = r_frame[39] ? C_B1 : C_B0;
      default:            w_dur = 20'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_us    <= '0;
      r_frame <= '0;
      r_bit   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick_last) begin
        r_tick <= '0;
        if (r_us != C_START) r_us <= r_us + 20'd1;
      end else begin
        r_tick <= r_tick + TW'(1);
      end
      if (w_last) begin
        r_tick <= '0;
        r_us   <= '0;
      end

      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          r_us   <= '0;
          if (!w_line) r_state <= S_HOST_LOW;
        end
        S_HOST_LOW: begin
          if (w_line) begin
            r_tick <= '0;
            r_us   <= '0;
            if (r_us >= C_START) begin
              r_state <= S_WAIT_DLY;
              r_busy  <= 1'b1;
              r_frame <= {hum_int, hum_dec, tmp_int, tmp_dec, w_csum};
              r_bit   <= 6'd39;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_DLY: if (w_last) begin r_state <= S_ACK_LO; r_dir <= 1'b1; end
        S_ACK_LO:   if (w_last) begin r_state <= S_ACK_HI; r_dir <= 1'b0; end
        S_ACK_HI:   if (w_last) begin r_state <= S_BIT_LO; r_dir <= 1'b1; end
        S_BIT_LO:   if (w_last) begin r_state <= S_BIT_HI; r_dir <= 1'b0; end
        S_BIT_HI: begin
          if (w_last) begin
            r_dir <= 1'b1;
            if (r_bit == 6'd0) begin
              r_state <= S_END_LO;
            end else begin
              r_state <= S_BIT_LO;
              r_bit   <= r_bit - 6'd1;
              r_frame <= {r_frame[38:0], 1'b0};
            end
          end
        end
        S_END_LO: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_dir   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
